// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: one outstanding imem read, enqueues {pc, instr} entries
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h1eceb000,
    parameter int          IQ_WIDTH = 64
) (
    input  logic                clk,
    input  logic                rst,
    output logic [31:0]         imem_addr,
    output logic [3:0]          imem_rmask,
    input  logic [31:0]         imem_rdata,
    input  logic                imem_resp,
    output logic [IQ_WIDTH-1:0] iq_wdata,
    output logic                iq_enqueue,
    input  logic                iq_full,
    input  logic                iq_dequeue,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_DISCARD} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] r_buf_instr;
    logic [31:0] w_pc_next;
    logic [31:0] w_buf_next;
    logic [31:0] w_instr;
    logic        w_accept;
    logic        w_req;
    logic        w_enq;

    // The queue does one operation per cycle and a dequeue takes precedence.
    assign w_accept = !iq_full && !iq_dequeue;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_buf_instr <= 32'h0;
        end else begin
            r_pc        <= w_pc_next;
            r_buf_instr <= w_buf_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_buf_next   = r_buf_instr;
        case (r_state)
            S_IDLE: begin
                if (!redirect_valid) w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (imem_resp) begin
                    if (redirect_valid || w_accept) begin
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next = S_HOLD;
                        w_buf_next   = imem_rdata;
                    end
                end else if (redirect_valid) begin
                    w_state_next = S_DISCARD;
                end
            end
            S_HOLD: begin
                if (redirect_valid || w_accept) w_state_next = S_IDLE;
            end
            default: begin
                if (imem_resp) w_state_next = S_IDLE;
            end
        endcase
        // A redirect overrides any pc advance, in every state.
        if (redirect_valid) begin
            w_pc_next = {redirect_pc[31:2], 2'b00};
        end else if (w_enq) begin
            w_pc_next = r_pc + 32'd4;
        end else begin
            w_pc_next = r_pc;
        end
    end

    always_comb begin
        w_req   = 1'b0;
        w_enq   = 1'b0;
        w_instr = r_buf_instr;
        case (r_state)
            S_IDLE: w_req = !redirect_valid;
            S_WAIT: begin
                if (imem_resp && !redirect_valid && w_accept) begin
                    w_enq   = 1'b1;
                    w_instr = imem_rdata;
                end
            end
            S_HOLD:  w_enq = !redirect_valid && w_accept;
            default: ;
        endcase
        if (rst) begin
            imem_addr  = RESET_PC;
            imem_rmask = 4'h0;
            iq_enqueue = 1'b0;
            iq_wdata   = '0;
        end else begin
            imem_addr  = r_pc;
            imem_rmask = w_req ? 4'hf : 4'h0;
            iq_enqueue = w_enq;
            iq_wdata   = IQ_WIDTH'({r_pc, w_instr});
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized check of fetch_unit against a transaction model
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h1eceb000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic [63:0] iq_wdata;
    logic        iq_enqueue;
    logic        iq_full;
    logic        iq_dequeue;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    fetch_unit #(.RESET_PC(RPC), .IQ_WIDTH(64)) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_rmask(imem_rmask),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .iq_wdata(iq_wdata), .iq_enqueue(iq_enqueue),
        .iq_full(iq_full), .iq_dequeue(iq_dequeue),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // memory model
    bit          const_mode;
    int          lat_fixed;
    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return const_mode ? 32'h00000013 : {a[15:0], ~a[15:0]};
    endfunction

    // reference model: transaction-level view of the fetch pipeline
    logic [31:0] m_pc;
    bit          m_out;
    bit          m_squash;
    bit          m_held;
    logic [31:0] m_word;

    logic [31:0] req_q[$];
    logic [63:0] enq_q[$];

    task automatic cyc(input logic rv, input logic [31:0] rp, input logic fl, input logic dq);
        logic        accept;
        logic        e_req;
        logic        e_enq;
        logic [63:0] e_data;
        redirect_valid = rv;
        redirect_pc    = rp;
        iq_full        = fl;
        iq_dequeue     = dq;
        imem_resp      = 1'b0;
        imem_rdata     = $urandom;
        if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_resp  = 1'b1;
                imem_rdata = mem_word(mem_addr);
                mem_busy   = 1'b0;
            end
        end
        #1;
        accept = !fl && !dq;
        e_req  = !m_out && !m_held && !rv;
        e_enq  = 1'b0;
        e_data = '0;
        if (!rv && accept) begin
            if (m_held) begin
                e_enq  = 1'b1;
                e_data = {m_pc, m_word};
            end else if (m_out && imem_resp && !m_squash) begin
                e_enq  = 1'b1;
                e_data = {m_pc, imem_rdata};
            end
        end
        check("imem_rmask", {60'h0, imem_rmask}, e_req ? 64'hf : 64'h0);
        check("imem_addr", {32'h0, imem_addr}, {32'h0, m_pc});
        check("iq_enqueue", {63'h0, iq_enqueue}, {63'h0, e_enq});
        if (e_enq) check("iq_wdata", iq_wdata, e_data);

        if (imem_rmask == 4'hf) begin
            mem_busy = 1'b1;
            mem_addr = imem_addr;
            mem_cnt  = (lat_fixed != 0) ? lat_fixed : int'($urandom_range(1, 4));
            req_q.push_back(imem_addr);
        end
        if (iq_enqueue) enq_q.push_back(iq_wdata);

        if (m_out && imem_resp) begin
            m_out = 1'b0;
            if (!m_squash && !rv && !e_enq) begin
                m_held = 1'b1;
                m_word = imem_rdata;
            end
            m_squash = 1'b0;
        end
        if (rv) begin
            if (m_out) m_squash = 1'b1;
            m_held = 1'b0;
            m_pc   = {rp[31:2], 2'b00};
        end else if (e_enq) begin
            m_pc   = m_pc + 32'd4;
            m_held = 1'b0;
        end
        if (e_req) m_out = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        imem_rdata = 32'h0; imem_resp = 1'b0;
        iq_full = 1'b1; iq_dequeue = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h12345678;
        const_mode = 1'b1; lat_fixed = 1; mem_busy = 1'b0; mem_cnt = 0; mem_addr = 32'h0;
        m_pc = RPC; m_out = 1'b0; m_squash = 1'b0; m_held = 1'b0; m_word = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        imem_resp = 1'b1; iq_full = 1'b0;
        #1;
        check("rst_addr", {32'h0, imem_addr}, {32'h0, RPC});
        check("rst_rmask", {60'h0, imem_rmask}, 64'h0);
        check("rst_enq", {63'h0, iq_enqueue}, 64'h0);
        check("rst_wdata", iq_wdata, 64'h0);
        rst = 1'b0; imem_resp = 1'b0;

        // back-to-back fetches with a 1-cycle memory
        idle_cycles(6);
        check("req0", {32'h0, req_q[0]}, 64'h1eceb000);
        check("req1", {32'h0, req_q[1]}, 64'h1eceb004);
        check("req2", {32'h0, req_q[2]}, 64'h1eceb008);
        check("enq0", enq_q[0], 64'h1eceb000_00000013);
        check("enq2", enq_q[2], 64'h1eceb008_00000013);

        // queue full for three cycles across the response
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        check("hold_cnt", 64'(enq_q.size()), 64'd3);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        check("hold_enq", enq_q[3], 64'h1eceb00c_00000013);

        // dequeue collides with the response
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        check("deq_enq", enq_q[4], 64'h1eceb010_00000013);

        // redirect while a slow response is in flight
        lat_fixed = 4;
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 32'h1eceb100, 1'b0, 1'b0);
        idle_cycles(3);
        lat_fixed = 1;
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        check("disc_cnt", 64'(enq_q.size()), 64'd5);
        check("disc_req", {32'h0, req_q[$]}, 64'h1eceb100);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);

        // redirect coincident with the response
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, 32'h00000202, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        check("coin_cnt", 64'(enq_q.size()), 64'd6);
        check("coin_req", {32'h0, req_q[$]}, 64'h00000200);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);

        // pc wrap at the top of the address space
        cyc(1'b1, 32'hfffffffc, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        check("wrap_enq", enq_q[$], 64'hfffffffc_00000013);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        check("wrap_req", {32'h0, req_q[$]}, 64'h0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);

        // randomized traffic
        const_mode = 1'b0;
        lat_fixed  = 0;
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 15) == 0, $urandom,
                $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
